// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer.
// Contents: opcode encodings, FSM state encoding, latched opcode class,
//           ALU operation, PC source and error code constants.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_ADDI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;

    localparam logic [1:0] PCSRC_SEQ    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode classifier.
// Ports:
//   opcode_i    IR[31:26]
//   op_class_o  instruction class (CLS_ILLEGAL for unlisted opcodes)
//   is_legal_o  1 when the opcode is one of the supported classes
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    output op_class_e  op_class_o,
    output logic       is_legal_o
);

    always_comb begin
        op_class_o = CLS_ILLEGAL;
        is_legal_o = 1'b1;
        case (opcode_i)
            OP_RTYPE: op_class_o = CLS_R;
            OP_ADDI:  op_class_o = CLS_ADDI;
            OP_LW:    op_class_o = CLS_LW;
            OP_SW:    op_class_o = CLS_SW;
            OP_BEQ:   op_class_o = CLS_BEQ;
            OP_J:     op_class_o = CLS_J;
            OP_HALT:  op_class_o = CLS_HALT;
            default: begin
                op_class_o = CLS_ILLEGAL;
                is_legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and selects, waits on the
// memory ready handshake, detects halt / illegal opcode / bus timeout and
// counts retired instructions.
//
// state  | meaning
// INIT   | after reset, all outputs 0, goes to FETCH
// FETCH  | instruction read; IR and PC load when mem_ready
// DECODE | classify opcode, latch class
// EXEC   | ALU op select; BEQ/J update PC and retire here
// MEM    | data access for LW/SW; SW retires on mem_ready
// WB     | register file write; retires
// HALT   | absorbing, halted=1, only reset exits
//
// Ports:
//   clk, reset            clock, async active-high reset
//   opcode, zero          IR[31:26], ALU zero flag
//   mem_ready             memory completes access this cycle
//   pc_we, ir_we, rf_we   datapath write enables
//   mem_req, mem_we       memory request / write
//   wb_sel, alu_op, pc_src datapath selects
//   halted, err_code      stop status and cause
//   retire_cnt            retired instruction count (wraps)
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             rf_we,
    output logic             wb_sel,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int              WAIT_W    = 8;
    // The timeout fires on the WAIT_MAX-th stalled cycle, i.e. while the
    // counter still holds WAIT_MAX-1 from the previous stalled cycles.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    state_e            state_q, state_d;
    op_class_e         class_q, class_d;
    op_class_e         dec_class;
    logic              dec_legal;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic [1:0]        err_q, err_d;
    logic              waiting;
    logic              timeout;
    logic              retire;

    multicycle_ctrl_decode u_decode (
        .opcode_i   (opcode),
        .op_class_o (dec_class),
        .is_legal_o (dec_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_INIT;
            class_q  <= CLS_R;
            wait_q   <= '0;
            retire_q <= '0;
            err_q    <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            class_q  <= class_d;
            wait_q   <= wait_d;
            retire_q <= retire_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        err_d   = err_q;
        retire  = 1'b0;
        waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
        timeout = waiting && (wait_q == WAIT_LAST);

        case (state_q)
            ST_INIT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                if (!dec_legal) begin
                    state_d = ST_HALT;
                    err_d   = ERR_ILLEGAL;
                end else if (dec_class == CLS_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_R, CLS_ADDI: state_d = ST_WB;
                    CLS_LW, CLS_SW:  state_d = ST_MEM;
                    CLS_BEQ, CLS_J: begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                    default: begin
                        state_d = ST_HALT;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (class_q == CLS_LW) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = ST_HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_INIT;
        endcase

        wait_d   = (waiting && (state_d == state_q)) ? wait_q + WAIT_W'(1) : '0;
        retire_d = retire ? retire_q + CNT_W'(1) : retire_q;
    end

    always_comb begin
        pc_we   = 1'b0;
        ir_we   = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        rf_we   = 1'b0;
        wb_sel  = 1'b0;
        alu_op  = ALU_ADD;
        pc_src  = PCSRC_SEQ;
        halted  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_R:   alu_op = ALU_FUNCT;
                    CLS_BEQ: begin
                        alu_op = ALU_SUB;
                        pc_we  = zero;
                        pc_src = PCSRC_BRANCH;
                    end
                    CLS_J: begin
                        pc_we  = 1'b1;
                        pc_src = PCSRC_JUMP;
                    end
                    default: alu_op = ALU_ADD;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (class_q == CLS_SW);
            end
            ST_WB: begin
                rf_we  = 1'b1;
                wb_sel = (class_q == CLS_LW);
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign err_code   = err_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a table of per-cycle vectors for a
// full instruction mix, plus hand-written sequences for reset, branch-not-taken,
// memory stalls, timeouts, halts and retire counter wrap (CNT_W=4).
module tb_multicycle_ctrl;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_HLT  = 6'b111111;
    localparam logic [5:0] T_ILL  = 6'b010101;

    // {pc_we, ir_we, mem_req, mem_we, rf_we, wb_sel, alu_op[3], pc_src[2], halted, err[2]}
    localparam logic [13:0] V_ZERO  = 14'b0;
    localparam logic [13:0] V_FETCH = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 2'd0};
    localparam logic [13:0] V_FWAIT = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 2'd0};
    localparam logic [13:0] V_EXR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 2'd0};
    localparam logic [13:0] V_WB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 2'd0};
    localparam logic [13:0] V_WBL   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 2'd0};
    localparam logic [13:0] V_MEMR  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 2'd0};
    localparam logic [13:0] V_MEMW  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 2'd0};
    localparam logic [13:0] V_BEQ1  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd1, 1'b0, 2'd0};
    localparam logic [13:0] V_BEQ0  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd1, 1'b0, 2'd0};
    localparam logic [13:0] V_JMP   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 1'b0, 2'd0};
    localparam logic [13:0] V_HLT0  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 2'd0};
    localparam logic [13:0] V_HLT1  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 2'd1};
    localparam logic [13:0] V_HLT2  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 2'd2};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, mem_req, mem_we, rf_we, wb_sel, halted;
    logic [2:0] alu_op;
    logic [1:0] pc_src, err_code;
    logic [3:0] retire_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        rdy;
        logic [13:0] exp_o;
        logic [3:0]  exp_r;
    } vec_t;

    vec_t tbl[$];

    multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .halted     (halted),
        .err_code   (err_code),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] outs();
        return {pc_we, ir_we, mem_req, mem_we, rf_we, wb_sel, alu_op, pc_src, halted, err_code};
    endfunction

    task automatic chk(input string name, input logic [13:0] exp_o, input logic [3:0] exp_r);
        logic [13:0] got_o;
        got_o = outs();
        n_checks++;
        if (got_o !== exp_o || retire_cnt !== exp_r) begin
            n_errors++;
            $display("FAIL %s @%0t: outputs=%b retire=%0d, required outputs=%b retire=%0d",
                     name, $time, got_o, retire_cnt, exp_o, exp_r);
        end
    endtask

    // Apply inputs in the low phase, then check before the next rising edge.
    task automatic sc(input string name, input logic [5:0] op, input logic z, input logic r,
                      input logic [13:0] exp_o, input logic [3:0] exp_r);
        @(negedge clk);
        opcode    = op;
        zero      = z;
        mem_ready = r;
        #1;
        chk(name, exp_o, exp_r);
    endtask

    // Releases reset at a falling edge; the following cycle is INIT.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("init", V_ZERO, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Instruction mix with mem_ready tied high: one row per cycle.
        tbl.push_back('{T_R,    1'b0, 1'b1, V_FETCH, 4'd0});
        tbl.push_back('{T_R,    1'b0, 1'b1, V_ZERO,  4'd0});
        tbl.push_back('{T_R,    1'b0, 1'b1, V_EXR,   4'd0});
        tbl.push_back('{T_R,    1'b0, 1'b1, V_WB,    4'd0});
        tbl.push_back('{T_ADDI, 1'b0, 1'b1, V_FETCH, 4'd1});
        tbl.push_back('{T_ADDI, 1'b0, 1'b1, V_ZERO,  4'd1});
        tbl.push_back('{T_ADDI, 1'b0, 1'b1, V_ZERO,  4'd1});
        tbl.push_back('{T_ADDI, 1'b0, 1'b1, V_WB,    4'd1});
        tbl.push_back('{T_LW,   1'b0, 1'b1, V_FETCH, 4'd2});
        tbl.push_back('{T_LW,   1'b0, 1'b1, V_ZERO,  4'd2});
        tbl.push_back('{T_LW,   1'b0, 1'b1, V_ZERO,  4'd2});
        tbl.push_back('{T_LW,   1'b0, 1'b1, V_MEMR,  4'd2});
        tbl.push_back('{T_LW,   1'b0, 1'b1, V_WBL,   4'd2});
        tbl.push_back('{T_SW,   1'b0, 1'b1, V_FETCH, 4'd3});
        tbl.push_back('{T_SW,   1'b0, 1'b1, V_ZERO,  4'd3});
        tbl.push_back('{T_SW,   1'b0, 1'b1, V_ZERO,  4'd3});
        tbl.push_back('{T_SW,   1'b0, 1'b1, V_MEMW,  4'd3});
        tbl.push_back('{T_BEQ,  1'b1, 1'b1, V_FETCH, 4'd4});
        tbl.push_back('{T_BEQ,  1'b1, 1'b1, V_ZERO,  4'd4});
        tbl.push_back('{T_BEQ,  1'b1, 1'b1, V_BEQ1,  4'd4});
        tbl.push_back('{T_J,    1'b0, 1'b1, V_FETCH, 4'd5});
        tbl.push_back('{T_J,    1'b0, 1'b1, V_ZERO,  4'd5});
        tbl.push_back('{T_J,    1'b0, 1'b1, V_JMP,   4'd5});
        tbl.push_back('{T_R,    1'b0, 1'b0, V_FWAIT, 4'd6});

        do_reset();
        foreach (tbl[i]) begin
            sc($sformatf("mix_row%0d", i), tbl[i].op, tbl[i].z, tbl[i].rdy,
               tbl[i].exp_o, tbl[i].exp_r);
        end

        // Reset pulse of 30 ns in the middle of a FETCH with mem_ready high.
        do_reset();
        sc("rst_pre_fetch", T_R, 1'b0, 1'b1, V_FETCH, 4'd0);
        #1 reset = 1'b1;
        #1 chk("rst_async_drop", V_ZERO, 4'd0);
        @(negedge clk); #1 chk("rst_held_a", V_ZERO, 4'd0);
        @(negedge clk); #1 chk("rst_held_b", V_ZERO, 4'd0);
        #10 reset = 1'b0;
        #1 chk("rst_init_cycle", V_ZERO, 4'd0);
        sc("rst_then_fetch", T_R, 1'b0, 1'b1, V_FETCH, 4'd0);

        // BEQ with zero=0: no PC load, still retires.
        do_reset();
        sc("beq0_fetch",  T_BEQ, 1'b0, 1'b1, V_FETCH, 4'd0);
        sc("beq0_decode", T_BEQ, 1'b0, 1'b1, V_ZERO,  4'd0);
        sc("beq0_exec",   T_BEQ, 1'b0, 1'b1, V_BEQ0,  4'd0);
        sc("beq0_next",   T_R,   1'b0, 1'b0, V_FWAIT, 4'd1);

        // LW with five stalled MEM cycles.
        do_reset();
        sc("lw_fetch",  T_LW, 1'b0, 1'b1, V_FETCH, 4'd0);
        sc("lw_decode", T_LW, 1'b0, 1'b1, V_ZERO,  4'd0);
        sc("lw_exec",   T_LW, 1'b0, 1'b0, V_ZERO,  4'd0);
        for (int i = 0; i < 5; i++) sc($sformatf("lw_mem_stall%0d", i), T_LW, 1'b0, 1'b0, V_MEMR, 4'd0);
        sc("lw_mem_ready", T_LW, 1'b0, 1'b1, V_MEMR, 4'd0);
        sc("lw_wb",        T_LW, 1'b0, 1'b0, V_WBL,  4'd0);
        sc("lw_next",      T_R,  1'b0, 1'b0, V_FWAIT, 4'd1);

        // Fetch timeout: 15 stalled cycles, then HALT with bus error.
        do_reset();
        for (int i = 1; i <= 15; i++) sc($sformatf("to_wait%0d", i), T_R, 1'b0, 1'b0, V_FWAIT, 4'd0);
        sc("to_halt",   T_R, 1'b0, 1'b1, V_HLT2, 4'd0);
        sc("to_sticky", T_R, 1'b0, 1'b1, V_HLT2, 4'd0);

        // mem_ready arriving on the 15th stalled cycle wins.
        do_reset();
        for (int i = 1; i <= 14; i++) sc($sformatf("late_wait%0d", i), T_R, 1'b0, 1'b0, V_FWAIT, 4'd0);
        sc("late_ready",  T_R, 1'b0, 1'b1, V_FETCH, 4'd0);
        sc("late_decode", T_R, 1'b0, 1'b1, V_ZERO,  4'd0);
        sc("late_exec",   T_R, 1'b0, 1'b1, V_EXR,   4'd0);

        // Illegal opcode after one retired instruction.
        do_reset();
        sc("ill_j_fetch",  T_J,   1'b0, 1'b1, V_FETCH, 4'd0);
        sc("ill_j_decode", T_J,   1'b0, 1'b1, V_ZERO,  4'd0);
        sc("ill_j_exec",   T_J,   1'b0, 1'b1, V_JMP,   4'd0);
        sc("ill_fetch",    T_ILL, 1'b0, 1'b1, V_FETCH, 4'd1);
        sc("ill_decode",   T_ILL, 1'b0, 1'b1, V_ZERO,  4'd1);
        sc("ill_halt",     T_ILL, 1'b0, 1'b1, V_HLT1,  4'd1);
        sc("ill_sticky",   T_R,   1'b0, 1'b1, V_HLT1,  4'd1);

        // HALT instruction: clean stop, no retire.
        do_reset();
        sc("hlt_fetch",  T_HLT, 1'b0, 1'b1, V_FETCH, 4'd0);
        sc("hlt_decode", T_HLT, 1'b0, 1'b1, V_ZERO,  4'd0);
        sc("hlt_halt",   T_HLT, 1'b0, 1'b1, V_HLT0,  4'd0);
        sc("hlt_sticky", T_R,   1'b0, 1'b1, V_HLT0,  4'd0);

        // Retire counter wraps from 15 to 0 with CNT_W=4.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            sc($sformatf("wrap_fetch%0d", i), T_J, 1'b0, 1'b1, V_FETCH, 4'(i));
            sc("wrap_decode", T_J, 1'b0, 1'b1, V_ZERO, 4'(i));
            sc("wrap_exec",   T_J, 1'b0, 1'b1, V_JMP,  4'(i));
        end
        sc("wrap_zero", T_R, 1'b0, 1'b0, V_FWAIT, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
